inv_mix_columns_seq: RTL and testbench

- Iterative AES InvMixColumns unit for the decryption datapath; it is the inverse of the encrypt-side MixColumns transform.
- Accepts a 128-bit state over a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock using the GF(2^8) inverse matrix.
- Presents the result on a held valid/ready output. Sits between InvShiftRows/InvSubBytes/AddRoundKey stages of the decryption round.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/inv_mix_columns_seq_if.sv | 22 ++
 rtl/inv_mix_column.sv | 21 ++
 rtl/inv_mix_columns_seq.sv | 101 ++++++++++
 tb/tb_inv_mix_columns_seq.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and widths, used by both the MixColumns and
// InvMixColumns datapaths.
package aes_pkg;

   localparam int STATE_W = 128;
   localparam int COL_W   = 32;
   localparam int BYTE_W  = 8;

   localparam logic [BYTE_W-1:0] GF_RED  = 8'h1b;
   localparam logic [BYTE_W-1:0] COEF_01 = 8'h01;
   localparam logic [BYTE_W-1:0] COEF_02 = 8'h02;
   localparam logic [BYTE_W-1:0] COEF_03 = 8'h03;
   localparam logic [BYTE_W-1:0] COEF_09 = 8'h09;
   localparam logic [BYTE_W-1:0] COEF_0B = 8'h0b;
   localparam logic [BYTE_W-1:0] COEF_0D = 8'h0d;
   localparam logic [BYTE_W-1:0] COEF_0E = 8'h0e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } imc_state_e;

   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
      xtime = a[BYTE_W-1] ? ({a[BYTE_W-2:0], 1'b0} ^ GF_RED) : {a[BYTE_W-2:0], 1'b0};
   endfunction

   // Only the constants used by the forward and inverse column matrices are supported.
   function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] coef);
      logic [BYTE_W-1:0] x2;
      logic [BYTE_W-1:0] x4;
      logic [BYTE_W-1:0] x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (coef)
         COEF_01: gf_mul = a;
         COEF_02: gf_mul = x2;
         COEF_03: gf_mul = x2 ^ a;
         COEF_09: gf_mul = x8 ^ a;
         COEF_0B: gf_mul = x8 ^ x2 ^ a;
         COEF_0D: gf_mul = x8 ^ x4 ^ a;
         COEF_0E: gf_mul = x8 ^ x4 ^ x2;
         default: gf_mul = '0;
      endcase
   endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Input/output handshake bundle of the InvMixColumns unit; slave is the unit side.
interface inv_mix_columns_seq_if;
   import aes_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] state_in;
   logic               out_valid;
   logic               out_ready;
   logic [STATE_W-1:0] state_out;

   modport master (
      output in_valid, state_in, out_ready,
      input  in_ready, out_valid, state_out
   );

   modport slave (
      input  in_valid, state_in, out_ready,
      output in_ready, out_valid, state_out
   );

endinterface

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column; row 0 byte in [31:24].
module inv_mix_column
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] col_in,
   output logic [COL_W-1:0] col_out
);

   logic [BYTE_W-1:0] a0, a1, a2, a3;

   assign a0 = col_in[31:24];
   assign a1 = col_in[23:16];
   assign a2 = col_in[15:8];
   assign a3 = col_in[7:0];

   assign col_out[31:24] = gf_mul(a0, COEF_0E) ^ gf_mul(a1, COEF_0B) ^ gf_mul(a2, COEF_0D) ^ gf_mul(a3, COEF_09);
   assign col_out[23:16] = gf_mul(a0, COEF_09) ^ gf_mul(a1, COEF_0E) ^ gf_mul(a2, COEF_0B) ^ gf_mul(a3, COEF_0D);
   assign col_out[15:8]  = gf_mul(a0, COEF_0D) ^ gf_mul(a1, COEF_09) ^ gf_mul(a2, COEF_0E) ^ gf_mul(a3, COEF_0B);
   assign col_out[7:0]   = gf_mul(a0, COEF_0B) ^ gf_mul(a1, COEF_0D) ^ gf_mul(a2, COEF_09) ^ gf_mul(a3, COEF_0E);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: transforms COLS_PER_CYCLE columns of the working
// register in place per clock, then holds the result until downstream takes it.
//
// state   | meaning
// IDLE    | waiting for a block, in_ready=1
// BUSY    | transforming columns, one group per cycle
// DONE    | result held on state_out with out_valid=1
module inv_mix_columns_seq
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   inv_mix_columns_seq_if.slave  bus,
   output logic                  busy
);

   localparam int         NCYC     = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST_CNT = 2'((NCYC - 1) * COLS_PER_CYCLE);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   imc_state_e         state_q, state_d;
   logic [1:0]         col_cnt_q, col_cnt_d;
   logic [STATE_W-1:0] work_q, work_d;

   logic [1:0]       sel_idx [COLS_PER_CYCLE];
   logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
   logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign sel_idx[g] = col_cnt_q + 2'(g);
      assign col_in[g]  = work_q[{sel_idx[g], 5'b0} +: COL_W];
      inv_mix_column u_col (
         .col_in  (col_in[g]),
         .col_out (col_out[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         col_cnt_q <= '0;
         work_q    <= '0;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         work_q    <= work_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      col_cnt_d     = col_cnt_q;
      work_d        = work_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               work_d    = bus.state_in;
               col_cnt_d = '0;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            busy = 1'b1;
            for (int i = 0; i < COLS_PER_CYCLE; i++) begin
               work_d[{sel_idx[i], 5'b0} +: COL_W] = col_out[i];
            end
            col_cnt_d = col_cnt_q + 2'(COLS_PER_CYCLE);
            if (col_cnt_q == LAST_CNT) state_d = ST_DONE;
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            // in_ready follows out_ready combinationally so a new block can
            // be taken on the same edge the result is consumed.
            if (bus.out_ready) begin
               bus.in_ready = 1'b1;
               if (bus.in_valid) begin
                  work_d    = bus.state_in;
                  col_cnt_d = '0;
                  state_d   = ST_BUSY;
               end else begin
                  state_d   = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_inv_mix_columns_seq;

   localparam logic [127:0] V1   = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6};
   localparam logic [127:0] GOLD = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5};
   localparam logic [127:0] C6   = {16{8'hc6}};
   localparam logic [127:0] JUNK = {4{32'hdeadbeef}};
   localparam logic [127:0] XV   = {32'h80ff0001, 32'hff000180, 32'h000180ff, 32'h0180ff00};

   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]   iv;
   logic [127:0] si [3];
   logic [2:0]   rdy;
   logic [2:0]   ir, ov, bsy;
   logic [127:0] so [3];

   bit rand_mode   = 1'b0;
   bit ready_force = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out [3];

   logic [127:0] q0 [$];
   logic [127:0] q1 [$];
   logic [127:0] q2 [$];

   inv_mix_columns_seq_if if0 ();
   inv_mix_columns_seq_if if1 ();
   inv_mix_columns_seq_if if2 ();

   assign if0.in_valid = iv[0];  assign if0.state_in = si[0];  assign if0.out_ready = rdy[0];
   assign if1.in_valid = iv[1];  assign if1.state_in = si[1];  assign if1.out_ready = rdy[1];
   assign if2.in_valid = iv[2];  assign if2.state_in = si[2];  assign if2.out_ready = rdy[2];
   assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid; assign so[0] = if0.state_out;
   assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid; assign so[1] = if1.state_out;
   assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid; assign so[2] = if2.state_out;

   inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if0), .busy(bsy[0]));
   inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if1), .busy(bsy[1]));
   inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if2), .busy(bsy[2]));

   // Reference model: generic shift-and-add GF(2^8) product and a matrix table.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = '0;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] mat_apply(input logic [127:0] v, input bit inv);
      int           m [4][4];
      logic [127:0] r;
      logic [7:0]   b [4];
      logic [7:0]   acc;
      r = '0;
      if (inv) m = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
      else     m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) b[row] = v[c*32 + (3-row)*8 +: 8];
         for (int row = 0; row < 4; row++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(b[k], 8'(m[row][k]));
            r[c*32 + (3-row)*8 +: 8] = acc;
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic qpush(input int d, input logic [127:0] v);
      case (d)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   function automatic int qsize(input int d);
      case (d)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [127:0] qpop(input int d);
      case (d)
         0: return q0.pop_front();
         1: return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic send(input int d, input logic [127:0] v, input logic [127:0] e);
      int n;
      n = 0;
      @(posedge clk); #1;
      iv[d] = 1'b1;
      si[d] = v;
      @(negedge clk);
      while (!ir[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ir[d]) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout dut%0d: in_ready 0, expected 1", d);
      end else begin
         @(posedge clk);
         qpush(d, e);
      end
      #1 iv[d] = 1'b0;
   endtask

   task automatic wait_out(input int d, input int exp_lat, input string name);
      int lat;
      lat = 0;
      while (!ov[d] && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check(name, 128'(lat), 128'(exp_lat));
   endtask

   // out_ready driver for dut1; the other two always accept.
   initial begin
      rdy = 3'b111;
      forever begin
         @(posedge clk); #2;
         rdy[0] = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   // Monitor: pops the expected result whenever an output is consumed.
   initial begin
      n_out = '{0, 0, 0};
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (!rst && ov[d] && rdy[d]) begin
               n_out[d]++;
               if (qsize(d) == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_unexpected dut%0d: got %h, expected no output", d, so[d]);
               end else begin
                  check($sformatf("sb_data dut%0d", d), so[d], qpop(d));
               end
            end
         end
      end
   end

   initial begin
      logic [127:0] v;
      int           base;
      int           n;
      rst = 1'b1;
      iv  = '0;
      for (int d = 0; d < 3; d++) si[d] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_in_ready dut%0d", d), ir[d], 1'b1);
         check($sformatf("rst_out_valid dut%0d", d), ov[d], 1'b0);
         check($sformatf("rst_busy dut%0d", d), bsy[d], 1'b0);
         check($sformatf("rst_state_out dut%0d", d), so[d], '0);
      end

      // Known vector at each column width
      send(0, V1, mat_apply(V1, 1'b1));
      wait_out(0, 4, "lat_c1");
      check("vec_c1", so[0], GOLD);
      @(posedge clk); @(negedge clk);
      check("pulse_c1", ov[0], 1'b0);
      send(1, V1, mat_apply(V1, 1'b1));
      wait_out(1, 2, "lat_c2");
      check("vec_c2", so[1], GOLD);
      send(2, V1, mat_apply(V1, 1'b1));
      wait_out(2, 1, "lat_c4");
      check("vec_c4", so[2], GOLD);

      // Backpressure, then same-edge accept of the next block
      ready_force = 1'b0;
      send(0, V1, mat_apply(V1, 1'b1));
      wait_out(0, 4, "bp_lat");
      for (int i = 0; i < 10; i++) begin
         check("bp_hold_data", so[0], GOLD);
         check("bp_hold_valid", ov[0], 1'b1);
         check("bp_in_ready", ir[0], 1'b0);
         iv[0] = (i == 3);
         si[0] = JUNK;
         @(posedge clk); @(negedge clk);
      end
      iv[0] = 1'b0;
      @(posedge clk); #1;
      ready_force = 1'b1;
      iv[0] = 1'b1;
      si[0] = C6;
      @(negedge clk);
      check("bp_accept_ready", ir[0], 1'b1);
      @(posedge clk);
      qpush(0, mat_apply(C6, 1'b1));
      #1 iv[0] = 1'b0;
      @(negedge clk);
      check("bp_busy_after", bsy[0], 1'b1);
      wait_out(0, 4, "bp2_lat");
      check("bp_c6", so[0], C6);

      // xtime reduction on every chained step
      send(0, XV, mat_apply(XV, 1'b1));
      wait_out(0, 4, "xt_lat");

      // Reset two cycles into BUSY
      v = {$urandom, $urandom, $urandom, $urandom};
      send(0, v, mat_apply(v, 1'b1));
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", ov[0], 1'b0);
      check("mid_rst_busy", bsy[0], 1'b0);
      check("mid_rst_state_out", so[0], '0);
      q0.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", ir[0], 1'b1);
      send(0, V1, mat_apply(V1, 1'b1));
      wait_out(0, 4, "post_rst_lat");
      check("post_rst_vec", so[0], GOLD);
      @(posedge clk); @(negedge clk);

      // Round trip through forward MixColumns under random stalls
      base = n_out[0];
      rand_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         v = {$urandom, $urandom, $urandom, $urandom};
         repeat ($urandom_range(0, 2)) @(posedge clk);
         send(0, mat_apply(v, 1'b0), v);
      end
      n = 0;
      while (q0.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("rt_drain", 128'(q0.size()), '0);
      check("rt_count", 128'(n_out[0] - base), 128'(1000));
      rand_mode = 1'b0;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
